// File: rtl/debug_pkg.sv
// Shared encodings and widths for the debug step controller.
package debug_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned DBG_SEL_BIT = 6;
  localparam int unsigned STEP_CNT_W  = 8;

  localparam logic [IDX_W-1:0] DBG_IDX_CYCLE = 5'd30;
  localparam logic [IDX_W-1:0] DBG_IDX_STEP  = 5'd31;

  // Pipeline advances in every state except HALT.
  function automatic logic state_advances(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level,
  output logic pulse_c
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Stage 1 is the synchronised level; stage 2 only serves the edge detect.
  assign level   = sync_q[1];
  assign pulse_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/debug_step_ctrl.sv
// Run/halt/step gating of the core pipeline and the addressed debug word readback.
module debug_step_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned NPROBE      = 16,
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     debug_en,
  input  logic                     debug_step,
  input  logic [ADDR_W-1:0]        debug_addr,
  output logic [IDX_W-1:0]         rf_raddr,
  input  logic [WORD_W-1:0]        rf_rdata,
  input  logic [WORD_W*NPROBE-1:0] probe_bus,
  output logic                     cpu_en,
  output logic                     halted,
  output logic [WORD_W-1:0]        debug_data
);

  localparam logic [STEP_CNT_W-1:0] STEP_LOAD = STEP_CNT_W'(STEP_CYCLES - 1);

  logic en_sync;
  logic step_pulse;
  logic en_pulse_unused;
  logic step_level_unused;
  logic unused_addr_bit;

  state_e                state_q,      state_d;
  logic [STEP_CNT_W-1:0] step_cnt_q,   step_cnt_d;
  logic                  cpu_en_q,     cpu_en_d;
  logic                  halted_q,     halted_d;
  logic [WORD_W-1:0]     cycle_cnt_q,  cycle_cnt_d;
  logic [WORD_W-1:0]     step_total_q, step_total_d;
  logic [WORD_W-1:0]     debug_data_q, debug_data_d;

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] probe_word;

  sync_edge u_sync_en (
    .clk     (clk),
    .rst     (rst),
    .async_i (debug_en),
    .level   (en_sync),
    .pulse_c (en_pulse_unused)
  );

  sync_edge u_sync_step (
    .clk     (clk),
    .rst     (rst),
    .async_i (debug_step),
    .level   (step_level_unused),
    .pulse_c (step_pulse)
  );

  assign idx             = debug_addr[IDX_W-1:0];
  assign rf_raddr        = idx;
  assign unused_addr_bit = debug_addr[5];

  // Next state; step edges seen outside HALT are simply dropped.
  always_comb begin
    state_d      = state_q;
    step_cnt_d   = step_cnt_q;
    step_total_d = step_total_q;
    unique case (state_q)
      ST_RUN: begin
        if (en_sync) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!en_sync) begin
          state_d = ST_RUN;
        end else if (step_pulse) begin
          state_d      = ST_STEP;
          step_cnt_d   = STEP_LOAD;
          step_total_d = step_total_q + WORD_W'(1);
        end
      end
      ST_STEP: begin
        if (!en_sync) begin
          state_d = ST_RUN;
        end else if (step_cnt_q == '0) begin
          state_d = ST_HALT;
        end else begin
          step_cnt_d = step_cnt_q - STEP_CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    cpu_en_d    = state_advances(state_d);
    halted_d    = (state_d == ST_HALT);
    cycle_cnt_d = cycle_cnt_q + WORD_W'(cpu_en_q);
  end

  // Readback mux; counters are read before this cycle's increment.
  always_comb begin
    probe_word = '0;
    for (int unsigned k = 0; k < NPROBE; k++) begin
      if (idx == IDX_W'(k)) probe_word = probe_bus[WORD_W*k +: WORD_W];
    end

    if (!debug_addr[DBG_SEL_BIT]) begin
      debug_data_d = rf_rdata;
    end else if (idx == DBG_IDX_CYCLE) begin
      debug_data_d = cycle_cnt_q;
    end else if (idx == DBG_IDX_STEP) begin
      debug_data_d = step_total_q;
    end else begin
      debug_data_d = probe_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      step_cnt_q   <= '0;
      cpu_en_q     <= 1'b0;
      halted_q     <= 1'b0;
      cycle_cnt_q  <= '0;
      step_total_q <= '0;
      debug_data_q <= '0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      cpu_en_q     <= cpu_en_d;
      halted_q     <= halted_d;
      cycle_cnt_q  <= cycle_cnt_d;
      step_total_q <= step_total_d;
      debug_data_q <= debug_data_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign halted     = halted_q;
  assign debug_data = debug_data_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Scoreboard bench: three controllers (1, 3 and 4 cycles per step) share one stimulus stream.
module tb_debug_step_ctrl;

  localparam int unsigned NP = 16;
  localparam int unsigned NI = 3;

  localparam int MODE_RUNNING  = 0;
  localparam int MODE_HALTED   = 1;
  localparam int MODE_STEPPING = 2;

  typedef struct packed {
    logic [NI-1:0]        cpu_en;
    logic [NI-1:0]        halted;
    logic [NI-1:0][31:0]  data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                debug_en;
  logic                debug_step;
  logic [6:0]          debug_addr;
  logic [32*NP-1:0]    probe_bus;
  logic [NI-1:0][4:0]  rf_raddr_w;
  logic [NI-1:0][31:0] rf_rdata_w;
  logic [NI-1:0][31:0] debug_data_w;
  logic [NI-1:0]       cpu_en_w;
  logic [NI-1:0]       halted_w;

  logic [31:0] regs   [32];
  logic [31:0] probes [NP];

  exp_t exp_q[$];
  bit   started = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  function automatic int step_len(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign rf_rdata_w[g] = regs[rf_raddr_w[g]];
    debug_step_ctrl #(
      .NPROBE      (NP),
      .STEP_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .debug_en   (debug_en),
      .debug_step (debug_step),
      .debug_addr (debug_addr),
      .rf_raddr   (rf_raddr_w[g]),
      .rf_rdata   (rf_rdata_w[g]),
      .probe_bus  (probe_bus),
      .cpu_en     (cpu_en_w[g]),
      .halted     (halted_w[g]),
      .debug_data (debug_data_w[g])
    );
  end

  task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, g, got, want, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [6:0] a, input logic [31:0] cyc,
                                           input logic [31:0] stp);
    int idx;
    idx = int'(a[4:0]);
    if (!a[6]) return regs[idx];
    if (idx == 30) return cyc;
    if (idx == 31) return stp;
    if (idx < int'(NP)) return probes[idx];
    return 32'h0;
  endfunction

  // Reference: mode per instance, input sample history, counters; one expectation per clock.
  initial begin : model
    int          mode   [NI];
    int          left   [NI];
    logic [31:0] cycles [NI];
    logic [31:0] steps  [NI];
    bit          adv    [NI];
    bit          en_h1, en_h2, en_h3, st_h1, st_h2, st_h3;
    bit          en_seen, step_edge;
    exp_t        e;
    forever begin
      @(posedge clk);
      e = '0;
      if (rst) begin
        for (int g = 0; g < int'(NI); g++) begin
          mode[g] = MODE_RUNNING; left[g] = 0; cycles[g] = 0; steps[g] = 0; adv[g] = 1'b0;
        end
        {en_h1, en_h2, en_h3, st_h1, st_h2, st_h3} = '0;
        started = 1'b1;
      end else if (started) begin
        en_seen   = en_h2;
        step_edge = st_h2 && !st_h3;
        for (int g = 0; g < int'(NI); g++) begin
          e.data[g] = ref_read(debug_addr, cycles[g], steps[g]);
          if (adv[g]) cycles[g] = cycles[g] + 32'd1;
          case (mode[g])
            MODE_RUNNING: if (en_seen) mode[g] = MODE_HALTED;
            MODE_HALTED: begin
              if (!en_seen) mode[g] = MODE_RUNNING;
              else if (step_edge) begin
                mode[g] = MODE_STEPPING; left[g] = step_len(g); steps[g] = steps[g] + 32'd1;
              end
            end
            default: begin
              if (!en_seen) mode[g] = MODE_RUNNING;
              else begin
                left[g]--;
                if (left[g] == 0) mode[g] = MODE_HALTED;
              end
            end
          endcase
          adv[g]      = (mode[g] != MODE_HALTED);
          e.cpu_en[g] = adv[g];
          e.halted[g] = (mode[g] == MODE_HALTED);
        end
        en_h3 = en_h2; en_h2 = en_h1; en_h1 = debug_en;
        st_h3 = st_h2; st_h2 = st_h1; st_h1 = debug_step;
      end
      if (started) exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (started) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 0, 32'd0, 32'd1);
        end else begin
          x = exp_q.pop_front();
          for (int g = 0; g < int'(NI); g++) begin
            chk("cpu_en", g, 32'(cpu_en_w[g]), 32'(x.cpu_en[g]));
            chk("halted", g, 32'(halted_w[g]), 32'(x.halted[g]));
            chk("debug_data", g, debug_data_w[g], x.data[g]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a step-button pattern and count enabled cycles per instance.
  task automatic step_window(input logic [19:0] pat, input int w0, input int w1, input int w2);
    int cnt [NI];
    logic [19:0] p;
    p = pat;
    for (int g = 0; g < int'(NI); g++) cnt[g] = 0;
    for (int i = 0; i < 20; i++) begin
      debug_step = p[i];
      tick();
      for (int g = 0; g < int'(NI); g++) cnt[g] += int'(cpu_en_w[g]);
    end
    chk("step_cycles", 0, 32'(cnt[0]), 32'(w0));
    chk("step_cycles", 1, 32'(cnt[1]), 32'(w1));
    chk("step_cycles", 2, 32'(cnt[2]), 32'(w2));
  endtask

  initial begin : stimulus
    int run_cnt [NI];
    rst = 1'b1; debug_en = 1'b0; debug_step = 1'b0; debug_addr = 7'h00;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[5] = 32'hDEADBEEF;
    for (int k = 0; k < int'(NP); k++) probes[k] = $urandom;
    probes[3] = 32'h00400010;
    for (int k = 0; k < int'(NP); k++) probe_bus[32*k +: 32] = probes[k];
    repeat (3) tick();
    for (int g = 0; g < int'(NI); g++) chk("reset_data", g, debug_data_w[g], 32'h0);

    // Free run for 100 cycles.
    rst = 1'b0; debug_addr = 7'h5E;
    for (int g = 0; g < int'(NI); g++) run_cnt[g] = 0;
    repeat (100) begin
      tick();
      for (int g = 0; g < int'(NI); g++) run_cnt[g] += int'(cpu_en_w[g]);
    end
    for (int g = 0; g < int'(NI); g++) chk("free_run", g, 32'(run_cnt[g]), 32'd100);

    // Halt request: still running two cycles on, halted on the third.
    debug_en = 1'b1;
    tick(); tick();
    chk("halt_latency_run", 0, 32'(cpu_en_w[0]), 32'd1);
    tick();
    for (int g = 0; g < int'(NI); g++) chk("halt_latency", g, 32'(halted_w[g]), 32'd1);
    repeat (50) tick();

    // Single presses, then a second edge landing mid-step.
    debug_addr = 7'h5F;
    step_window(20'h003FF, 1, 3, 4);
    for (int g = 0; g < int'(NI); g++) chk("step_count_1", g, debug_data_w[g], 32'd1);
    step_window(20'h003FF, 1, 3, 4);
    step_window(20'h0003D, 2, 3, 4);
    chk("step_count_dbl", 0, debug_data_w[0], 32'd4);
    chk("step_count_dbl", 2, debug_data_w[2], 32'd3);

    // Address decode corners.
    debug_addr = 7'h05; tick(); chk("rf_read", 0, debug_data_w[0], 32'hDEADBEEF);
    debug_addr = 7'h25; tick(); chk("rf_bit5", 1, debug_data_w[1], 32'hDEADBEEF);
    debug_addr = 7'h43; tick(); chk("probe3", 0, debug_data_w[0], 32'h00400010);
    debug_addr = 7'h4F; tick(); chk("probe15", 2, debug_data_w[2], probes[15]);
    debug_addr = 7'h50; tick(); chk("probe_oob", 0, debug_data_w[0], 32'h0);
    debug_addr = 7'h5D; tick(); chk("idx29", 1, debug_data_w[1], 32'h0);

    // Reset in the middle of a step, with en and the step button held high.
    debug_addr = 7'h5F; debug_step = 1'b1;
    repeat (4) tick();
    chk("mid_step", 2, 32'(cpu_en_w[2]), 32'd1);
    rst = 1'b1;
    tick();
    for (int g = 0; g < int'(NI); g++) begin
      chk("rst_cpu_en", g, 32'(cpu_en_w[g]), 32'd0);
      chk("rst_data", g, debug_data_w[g], 32'h0);
    end
    tick();
    rst = 1'b0;
    repeat (6) tick();
    for (int g = 0; g < int'(NI); g++) begin
      chk("post_rst_halt", g, 32'(halted_w[g]), 32'd1);
      chk("post_rst_steps", g, debug_data_w[g], 32'h0);
    end
    debug_addr = 7'h5E; tick();
    chk("post_rst_cycles", 0, debug_data_w[0], 32'd2);

    // Randomised traffic.
    debug_step = 1'b0; debug_en = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) debug_en = ~debug_en;
      if ($urandom_range(0, 3) == 0) debug_step = ~debug_step;
      case ($urandom_range(0, 3))
        0: debug_addr = 7'h5E;
        1: debug_addr = 7'h5F;
        default: debug_addr = 7'($urandom);
      endcase
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
